// File: rtl/alu_exec_seq.sv
// alu_exec_seq: MIPS-style execute-stage ALU with a valid/ready handshake.
// Simple operations finish in one cycle. Multiply (shift-add) and divide
// (restoring) run one step per clock for WIDTH clocks. The result and its
// flags are registered and stay stable until the consumer takes them.
`timescale 1ns/1ps

module alu_exec_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUop,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_SLT,
        OP_MUL,
        OP_DIV,
        OP_NOP,
        OP_ILL
    } op_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;

    op_t              op;
    logic [WIDTH-1:0] quick_result;
    logic             quick_err;
    logic [WIDTH-1:0] mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_fits;
    logic [WIDTH-1:0] div_quo;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Decode the main-control class and function field into one operation
    always_comb begin
        op = OP_ILL;
        case (ALUop)
            3'b000: op = OP_ADD;
            3'b001: op = OP_SUB;
            3'b010: begin
                case (func)
                    6'b100000: op = OP_ADD;
                    6'b100010: op = OP_SUB;
                    6'b100100: op = OP_AND;
                    6'b100101: op = OP_OR;
                    6'b101010: op = OP_SLT;
                    6'b011000: op = OP_MUL;
                    6'b011010: op = OP_DIV;
                    6'b000000: op = OP_NOP;
                    default:   op = OP_ILL;
                endcase
            end
            default: op = OP_ILL;
        endcase
    end

    // Single-cycle datapath; divide-by-zero and illegal ops also resolve here
    always_comb begin
        quick_result = '0;
        quick_err    = 1'b0;
        case (op)
            OP_ADD: quick_result = a + b;
            OP_SUB: quick_result = a - b;
            OP_AND: quick_result = a & b;
            OP_OR:  quick_result = a | b;
            OP_SLT: quick_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_DIV: begin
                quick_result = '1;
                quick_err    = 1'b1;
            end
            OP_ILL: quick_err = 1'b1;
            default: quick_result = '0;
        endcase
    end

    // One shift-add step and one restoring-divide step from the working registers
    always_comb begin
        mul_sum   = opb[0] ? (acc + opa) : acc;
        div_shift = {acc, opa[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb};
        div_fits  = ~div_diff[WIDTH];
        div_quo   = {opa[WIDTH-2:0], div_fits};
    end

    // Control FSM plus the iterative working registers and the result/flag outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            result <= '0;
            zero   <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa <= a;
                        opb <= b;
                        acc <= '0;
                        if (op == OP_MUL) begin
                            cnt   <= CNT_LOAD;
                            state <= MUL;
                        end else if ((op == OP_DIV) && (b != '0)) begin
                            cnt   <= CNT_LOAD;
                            state <= DIV;
                        end else begin
                            result <= quick_result;
                            zero   <= (quick_result == '0);
                            err    <= quick_err;
                            state  <= DONE;
                        end
                    end
                end
                MUL: begin
                    acc <= mul_sum;
                    opa <= {opa[WIDTH-2:0], 1'b0};
                    opb <= {1'b0, opb[WIDTH-1:1]};
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        result <= mul_sum;
                        zero   <= (mul_sum == '0);
                        err    <= 1'b0;
                        state  <= DONE;
                    end
                end
                DIV: begin
                    acc <= div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                    opa <= div_quo;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        result <= div_quo;
                        zero   <= (div_quo == '0);
                        err    <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_seq.sv
// tb_alu_exec_seq: directed and randomized checks of alu_exec_seq (WIDTH=32)
// against an arithmetic reference model.
`timescale 1ns/1ps

module tb_alu_exec_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   ALUop;
    logic [5:0]   func;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         err;

    int passCount = 0;
    int failCount = 0;
    int checkCount = 0;

    alu_exec_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUop     (ALUop),
        .func      (func),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .err       (err)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Safety net so the run always ends
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference behaviour: plain arithmetic on the operation definitions
    task automatic refModel(input logic [2:0] op, input logic [5:0] fn,
                            input logic [W-1:0] x, input logic [W-1:0] y,
                            output logic [W-1:0] r, output logic e, output int lat);
        logic [63:0] prod;
        r = '0;
        e = 1'b0;
        lat = 0;
        if (op == 3'b000) r = x + y;
        else if (op == 3'b001) r = x - y;
        else if (op == 3'b010 && fn == 6'b100000) r = x + y;
        else if (op == 3'b010 && fn == 6'b100010) r = x - y;
        else if (op == 3'b010 && fn == 6'b100100) r = x & y;
        else if (op == 3'b010 && fn == 6'b100101) r = x | y;
        else if (op == 3'b010 && fn == 6'b101010) r = ($signed(x) < $signed(y)) ? 1 : 0;
        else if (op == 3'b010 && fn == 6'b000000) r = 0;
        else if (op == 3'b010 && fn == 6'b011000) begin
            prod = 64'(x) * 64'(y);
            r = prod[W-1:0];
            lat = W;
        end else if (op == 3'b010 && fn == 6'b011010) begin
            if (y == 0) begin
                r = '1;
                e = 1'b1;
            end else begin
                r = x / y;
                lat = W;
            end
        end else begin
            r = 0;
            e = 1'b1;
        end
    endtask

    // Present one request; returns #1 after the accepting edge
    task automatic applyStimulus(input logic [2:0] op, input logic [5:0] fn,
                                 input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        ALUop = op;
        func = fn;
        a = x;
        b = y;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Issue a request, scramble the inputs while busy, and check the delivered result
    task automatic doOp(input string tag, input logic [2:0] op, input logic [5:0] fn,
                        input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] expR;
        logic         expE;
        int           expLat;
        int           lat;
        refModel(op, fn, x, y, expR, expE, expLat);
        applyStimulus(op, fn, x, y);
        lat = 0;
        while (!out_valid && lat < 100) begin
            in_valid = 1'($urandom_range(0, 1));
            ALUop = 3'($urandom);
            func = 6'($urandom);
            a = $urandom;
            b = $urandom;
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        checkOutput({tag, " latency"}, 64'(lat), 64'(expLat));
        checkOutput({tag, " result"}, 64'(result), 64'(expR));
        checkOutput({tag, " zero"}, 64'(zero), 64'(expR == 0));
        checkOutput({tag, " err"}, 64'(err), 64'(expE));
        if (out_ready) begin
            @(posedge clk);
            #1;
            checkOutput({tag, " in_ready"}, 64'(in_ready), 64'(1));
        end
    endtask

    initial begin
        logic [2:0]   rop;
        logic [5:0]   rfn;
        logic [W-1:0] rx;
        logic [W-1:0] ry;

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        ALUop = 3'b000;
        func = 6'b000000;
        a = '0;
        b = '0;

        // Reset state
        #12;
        checkOutput("reset result", 64'(result), 64'(0));
        checkOutput("reset zero", 64'(zero), 64'(0));
        checkOutput("reset err", 64'(err), 64'(0));
        checkOutput("reset out_valid", 64'(out_valid), 64'(0));
        checkOutput("reset in_ready", 64'(in_ready), 64'(1));

        // Release reset; the very next rising edge accepts the add
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        doOp("add 5+7", 3'b010, 6'b100000, 32'd5, 32'd7);

        // Signed compare, then a sub giving zero
        doOp("slt -1<1", 3'b010, 6'b101010, 32'hFFFF_FFFF, 32'd1);
        doOp("sub 9-9", 3'b001, 6'b111111, 32'd9, 32'd9);

        // Multiply
        doOp("mul 7*6", 3'b010, 6'b011000, 32'd7, 32'd6);
        doOp("mul ffffffff*2", 3'b010, 6'b011000, 32'hFFFF_FFFF, 32'd2);

        // Divide and divide-by-zero
        doOp("div 100/7", 3'b010, 6'b011010, 32'd100, 32'd7);
        doOp("div by 0", 3'b010, 6'b011010, 32'd100, 32'd0);

        // Reset in the middle of a divide
        applyStimulus(3'b010, 6'b011010, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset result", 64'(result), 64'(0));
        checkOutput("midreset err", 64'(err), 64'(0));
        checkOutput("midreset zero", 64'(zero), 64'(0));
        checkOutput("midreset out_valid", 64'(out_valid), 64'(0));
        checkOutput("midreset in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("postreset out_valid", 64'(out_valid), 64'(0));
        checkOutput("postreset in_ready", 64'(in_ready), 64'(1));

        // Illegal operations
        doOp("illegal ALUop 011", 3'b011, 6'b100000, 32'd3, 32'd4);
        doOp("illegal func", 3'b010, 6'b111111, 32'd3, 32'd4);

        // Backpressure: result must hold and no request may be accepted
        out_ready = 1'b0;
        doOp("bp mul 7*6", 3'b010, 6'b011000, 32'd7, 32'd6);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            ALUop = 3'b000;
            a = $urandom;
            b = 32'd1;
            @(posedge clk);
            #1;
            checkOutput("bp result", 64'(result), 64'(42));
            checkOutput("bp out_valid", 64'(out_valid), 64'(1));
            checkOutput("bp in_ready", 64'(in_ready), 64'(0));
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp release in_ready", 64'(in_ready), 64'(1));
        checkOutput("bp release out_valid", 64'(out_valid), 64'(0));

        // Randomized operations against the reference model
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 11))
                0:  begin rop = 3'b000; rfn = 6'($urandom); end
                1:  begin rop = 3'b001; rfn = 6'($urandom); end
                2:  begin rop = 3'b010; rfn = 6'b100000; end
                3:  begin rop = 3'b010; rfn = 6'b100010; end
                4:  begin rop = 3'b010; rfn = 6'b100100; end
                5:  begin rop = 3'b010; rfn = 6'b100101; end
                6:  begin rop = 3'b010; rfn = 6'b101010; end
                7:  begin rop = 3'b010; rfn = 6'b011000; end
                8:  begin rop = 3'b010; rfn = 6'b011010; end
                9:  begin rop = 3'b010; rfn = 6'b000000; end
                10: begin rop = 3'b1_00 | 3'($urandom_range(0, 3)); rfn = 6'($urandom); end
                default: begin rop = 3'b010; rfn = 6'b111110; end
            endcase
            rx = $urandom;
            ry = $urandom;
            if ($urandom_range(0, 7) == 0) ry = '0;
            else if ($urandom_range(0, 7) == 0) ry = rx;
            else if ($urandom_range(0, 3) == 0) ry = 32'($urandom_range(1, 300));
            doOp("random", rop, rfn, rx, ry);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/alu_exec_seq.md
ALU_EXEC_SEQ -- requirements
Module: alu_exec_seq

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits, legal range 8..64.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 ALUop  input  3  main-control operation class.
REQ-007 func  input  6  R-type function field.
REQ-008 a  input  WIDTH  operand A (rs).
REQ-009 b  input  WIDTH  operand B (rt or immediate).
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 result  output  WIDTH  registered result.
REQ-013 zero  output  1  registered flag, set when result equals 0.
REQ-014 err  output  1  registered flag: illegal operation or divide-by-zero.

Function
REQ-015 States SHALL be IDLE, MUL, DIV and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-016 Accept edge A is any rising edge with in_valid=1 and in_ready=1; A SHALL sample ALUop, func, a and b.
REQ-017 Decode for ALUop=010, by func:
- 100000 add
- 100010 sub
- 100100 and
- 100101 or
- 101010 slt (signed compare)
- 011000 mul
- 011010 div
- 000000 nop
REQ-018 ALUop=000 SHALL decode as add and ALUop=001 as sub, regardless of func.
REQ-019 Any other ALUop or func combination SHALL produce result=0 and err=1, with single-cycle timing.
REQ-020 Add and sub SHALL wrap modulo 2^WIDTH with no overflow flag; slt SHALL give 1 or 0, zero-extended; nop SHALL give 0.
REQ-021 Single-cycle ops: at edge A, result, zero and err SHALL load and the state SHALL go to DONE; out_valid is high in the cycle after A.
REQ-022 Mul: at edge A the state SHALL go to MUL.
- One shift-add step per edge, unsigned.
- Edge A+WIDTH performs the last step and enters DONE.
- result = low WIDTH bits of a*b (identical to a signed product's low bits).
REQ-023 Div with b≠0: at edge A the state SHALL go to DIV.
- One restoring step per edge, unsigned.
- Edge A+WIDTH enters DONE.
- result = floor(a/b); the remainder is discarded.
REQ-024 Div with b=0 SHALL skip the DIV state and take single-cycle timing, with result all-ones and err=1.
REQ-025 An iteration counter of ceil(log2(WIDTH+1)) bits SHALL load WIDTH at edge A and decrement once per step; DONE is entered when it reaches 0.
REQ-026 In DONE, result, zero and err SHALL stay stable while out_ready=0.
REQ-027 A DONE-state edge with out_ready=1 SHALL return the state to IDLE.
REQ-028 A new request is accepted no earlier than the edge after the state returns to IDLE; accept and deliver never overlap.
REQ-029 In MUL and DIV, changes on in_valid, ALUop, func, a and b SHALL have no effect.
REQ-030 In MUL and DIV, out_valid SHALL stay 0; zero and err SHALL hold their prior values until DONE loads them.
REQ-031 The block SHALL take its own internal copies of a and b at edge A.

Reset
REQ-032 rst_n=0 SHALL take effect immediately, regardless of clk, in any state including mid-MUL or mid-DIV.
REQ-033 While rst_n=0, the block SHALL force:
- state=IDLE and iteration counter=0
- result=0, zero=0, err=0
- out_valid=0 and in_ready=1
REQ-034 An operation interrupted by reset SHALL be discarded, with no result delivered.
REQ-035 On the first rising edge after rst_n rises, the block SHALL accept a request if in_valid=1.

Verification
REQ-036 WIDTH=32, ALUop=010, func=100000, a=5, b=7, out_ready=1 -> out_valid in the cycle after A, result=12, zero=0, err=0, then in_ready=1.
REQ-037 ALUop=010, func=101010, a=0xFFFFFFFF, b=1 -> result=1; then ALUop=001, a=9, b=9 -> result=0, zero=1.
REQ-038 func=011000, a=7, b=6 -> out_valid first high after edge A+32, result=42; with a=0xFFFFFFFF, b=2 -> result=0xFFFFFFFE.
REQ-039 func=011010, a=100, b=7 -> result=14 after edge A+32; with b=0 -> result=0xFFFFFFFF, err=1, out_valid in the cycle after A.
REQ-040 Backpressure: after a mul result, hold out_ready=0 for 5 cycles and toggle in_valid/a -> result held at 42, in_ready=0, no new accept; then out_ready=1 -> IDLE.
REQ-041 Assert rst_n=0 at iteration 10 of a div, and separately drive ALUop=011 -> reset gives all outputs 0 and in_ready=1 at once; the illegal op gives err=1, result=0.
